// File: rtl/dense_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dense_pkg                                                        |
// | Purpose  : Shared constants and types for the dense-layer frame            |
// |            deserializer: default frame size / sample width, the collector  |
// |            FSM state encoding, and the index-width helper.                 |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package dense_pkg;

  localparam int N_DEFAULT  = 120;
  localparam int DW_DEFAULT = 16;

  // Width of an index that addresses every element of a frame.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEFAULT = idx_width(N_DEFAULT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dense_deser_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dense_deser_ctrl                                                 |
// | Purpose  : Framing controller for the dense-layer deserializer. Tracks the |
// |            position within a frame, decides where each accepted sample is  |
// |            written and raises the frame-complete / framing-error pulses.   |
// | Ports    : clk, rst_n (async, active-low)                                   |
// |            valid_in, frame_start_in, frame_end_in  - serial stream markers  |
// |            wr_en, wr_idx   - buffer write strobe and element index          |
// |            frame_valid     - registered pulse, frame complete               |
// |            frame_err       - registered pulse, framing violation            |
// |            busy            - registered, high while collecting a frame      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dense_deser_ctrl
  import dense_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_in,
  input  logic          frame_start_in,
  input  logic          frame_end_in,
  output logic          wr_en,
  output logic [IW-1:0] wr_idx,
  output logic          frame_valid,
  output logic          frame_err,
  output logic          busy
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  state_t        state;
  logic [IW-1:0] idx;

  // The write happens on the same edge that accepts the sample, so the
  // strobe is decoded combinationally from the current state. A start
  // marker always lands in element 0, whatever state it arrives in.
  assign wr_en  = valid_in & (frame_start_in | (state == ST_COLLECT));
  assign wr_idx = frame_start_in ? '0 : idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (valid_in) begin
        case (state)
          ST_COLLECT: begin
            if (frame_start_in) begin
              // Restart wins over an end marker on the same sample.
              frame_err <= 1'b1;
              idx       <= ONE_IDX;
            end else if (frame_end_in) begin
              if (idx == LAST_IDX) frame_valid <= 1'b1;
              else                 frame_err   <= 1'b1;
              state <= ST_IDLE;
              idx   <= '0;
              busy  <= 1'b0;
            end else if (idx == LAST_IDX) begin
              // Buffer full but no end marker: discard until next start.
              frame_err <= 1'b1;
              state     <= ST_DROP;
              idx       <= '0;
              busy      <= 1'b0;
            end else begin
              idx <= idx + ONE_IDX;
            end
          end
          default: begin
            // IDLE and DROP share everything except the stray-sample pulse;
            // in DROP the violation was already reported.
            if (frame_start_in) begin
              if (frame_end_in) begin
                frame_err <= 1'b1;
                state     <= ST_IDLE;
                idx       <= '0;
                busy      <= 1'b0;
              end else begin
                state <= ST_COLLECT;
                idx   <= ONE_IDX;
                busy  <= 1'b1;
              end
            end else if (state == ST_IDLE) begin
              frame_err <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dense_frame_deserial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dense_frame_deserial                                             |
// | Purpose  : Packs a framed serial sample stream back into a parallel N x DW |
// |            vector for the next dense layer. Element k of a frame lands in  |
// |            frame_data[k*DW +: DW]. Malformed frames are flagged.           |
// | Ports    : clk, rst_n (async, active-low)                                   |
// |            valid_in, frame_start_in, frame_end_in, data_in - serial input   |
// |            frame_data  - packed frame buffer, element 0 at LSBs             |
// |            frame_valid - one-cycle pulse, frame_data is a complete frame    |
// |            frame_err   - one-cycle pulse per framing violation             |
// |            busy        - high while a frame is being collected             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dense_frame_deserial
  import dense_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic            frame_start_in,
  input  logic            frame_end_in,
  input  logic [DW-1:0]   data_in,
  output logic [N*DW-1:0] frame_data,
  output logic            frame_valid,
  output logic            frame_err,
  output logic            busy
);

  localparam int IW = idx_width(N);

  logic          wr_en;
  logic [IW-1:0] wr_idx;

  dense_deser_ctrl #(
    .N  (N),
    .IW (IW)
  ) u_ctrl (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_in       (valid_in),
    .frame_start_in (frame_start_in),
    .frame_end_in   (frame_end_in),
    .wr_en          (wr_en),
    .wr_idx         (wr_idx),
    .frame_valid    (frame_valid),
    .frame_err      (frame_err),
    .busy           (busy)
  );

  // One register per element; each decodes its own write select so the
  // buffer is a plain bank of enabled flops feeding frame_data directly.
  for (genvar k = 0; k < N; k++) begin : g_elem
    logic [DW-1:0] elem_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        elem_q <= '0;
      end else if (wr_en && (wr_idx == IW'(k))) begin
        elem_q <= data_in;
      end
    end

    assign frame_data[k*DW +: DW] = elem_q;
  end

endmodule
`default_nettype wire
